// File: rtl/reciprocal_table_writer.sv
// Builds the Q1.(WIDTH_OUT-1) reciprocal table in RAM: x_a by one serial divide, y_a = unity/x_a by a second.
// Optional RECIP_WRITER_CKSUM_EN adds a running checksum port over all accepted write words.
module reciprocal_table_writer #(
   parameter int unsigned WIDTH_IN  = 17,
   parameter int unsigned WIDTH_OUT = 24,
   parameter int unsigned LUT_SIZE  = 1024,
   parameter int unsigned X_MAX     = 76800,
   localparam int unsigned AW       = $clog2(LUT_SIZE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 wr_en,
   input  logic                 wr_ready,
   output logic [AW-1:0]        wr_addr,
   output logic [WIDTH_OUT-1:0] wr_data
`ifdef RECIP_WRITER_CKSUM_EN
   ,
   output logic [WIDTH_OUT-1:0] cksum
`endif
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 5;
   localparam logic [WIDTH_OUT-1:0] UNITY = {1'b1, {(WIDTH_OUT-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MAP   = 3'd1,
      S_RECIP = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic           busy_nxt;
   logic           done_nxt;
   logic           wr_en_nxt;

   logic [DW-1:0]  num;
   logic [DW-1:0]  rem;
   logic [DW-1:0]  den;
   logic [CW-1:0]  cnt;

   logic           step_last;
   logic           last_entry;
   logic           accept_start;
   logic           accept_wr;
   logic [AW-1:0]  a_load;
   logic [DW-1:0]  map_num;
   logic [DW:0]    rem_sh;
   logic [DW:0]    diff;
   logic           q_bit;
   logic [DW-1:0]  rem_nxt;
   logic [DW-1:0]  num_nxt;

   assign step_last    = (cnt == CW'(31));
   assign last_entry   = (wr_addr == AW'(LUT_SIZE-1));
   assign accept_start = (state == S_IDLE) && start;
   assign accept_wr    = (state == S_WRITE) && wr_ready;

   // Numerator for the index-to-x mapping: a*X_MAX + LUT_SIZE-2 gives the ceiling divide.
   assign a_load  = accept_start ? '0 : wr_addr + AW'(1);
   assign map_num = DW'(a_load) * DW'(X_MAX) + DW'(LUT_SIZE-2);

   // One restoring-divide step; quotient bits shift into num from the bottom.
   assign rem_sh  = {rem, num[DW-1]};
   assign diff    = rem_sh - {1'b0, den};
   assign q_bit   = ~diff[DW];
   assign rem_nxt = q_bit ? diff[DW-1:0] : rem_sh[DW-1:0];
   assign num_nxt = {num[DW-2:0], q_bit};

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_MAP;
         S_MAP:   if (step_last) state_nxt = S_RECIP;
         S_RECIP: if (step_last) state_nxt = S_WRITE;
         S_WRITE: if (wr_ready) state_nxt = last_entry ? S_DONE : S_MAP;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the next state so the status flags come straight from flops
   always_comb begin
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      wr_en_nxt = 1'b0;
      case (state_nxt)
         S_MAP, S_RECIP: busy_nxt = 1'b1;
         S_WRITE: begin
            busy_nxt  = 1'b1;
            wr_en_nxt = 1'b1;
         end
         S_DONE:  done_nxt = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         wr_en <= 1'b0;
      end else begin
         busy  <= busy_nxt;
         done  <= done_nxt;
         wr_en <= wr_en_nxt;
      end
   end

   // Divider datapath, entry index and write word
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_addr <= '0;
         wr_data <= '0;
         num     <= '0;
         rem     <= '0;
         den     <= '0;
         cnt     <= '0;
      end else if (accept_start || (accept_wr && !last_entry)) begin
         wr_addr <= a_load;
         num     <= map_num;
         rem     <= '0;
         den     <= DW'(LUT_SIZE-1);
         cnt     <= '0;
      end else if (state == S_MAP || state == S_RECIP) begin
         cnt <= cnt + CW'(1);
         if (step_last && state == S_MAP) begin
            num <= DW'(UNITY);
            rem <= '0;
            den <= DW'(num_nxt[WIDTH_IN-1:0]);
         end else begin
            num <= num_nxt;
            rem <= rem_nxt;
         end
         // x of 0 or 1 saturates to unity; the divide still runs its full length
         if (step_last && state == S_RECIP)
            wr_data <= (den <= DW'(1)) ? UNITY : WIDTH_OUT'(num_nxt);
      end
   end

`ifdef RECIP_WRITER_CKSUM_EN
   // Running sum of accepted words, restarted with each build
   always_ff @(posedge clk) begin
      if (reset || accept_start) cksum <= '0;
      else if (accept_wr)        cksum <= cksum + wr_data;
   end
`endif

endmodule
